// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and defaults for the serial subtractor
package serial_sub_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fs_cell.sv
// rtl/fs_cell.sv - combinational full subtractor from two half subtractors
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // first half subtractor: a - b
    assign hs1_d = a ^ b;
    assign hs1_b = ~a & b;

    // second half subtractor: (a - b) - bin
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    // either stage borrowing means the cell borrows
    assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a - b, LSB first, one bit per clock
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borr
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] d_sh;
    logic [WIDTH-1:0] d_next;
    logic [CW-1:0]    cnt;
    logic             bin_q;
    logic             cell_d;
    logic             cell_bout;
    logic             last_bit;

    fs_cell u_fs_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // on the last bit the new MSB joins the bits already collected
    assign d_next   = {cell_d, d_sh};
    assign last_bit = (cnt == LAST);

    // next-state: start wins over abort in IDLE, abort only matters in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)         state_d = ST_IDLE;
                else if (last_bit) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state register plus flopped busy/done so outputs come straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != ST_IDLE);
            done    <= (state_d == ST_DONE);
        end
    end

    // datapath: capture on accept, shift one bit per RUN edge, publish on last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            cnt   <= '0;
            bin_q <= 1'b0;
            diff  <= '0;
            borr  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        cnt   <= '0;
                        bin_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!abort) begin
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        d_sh  <= d_next[WIDTH-1:1];
                        bin_q <= cell_bout;
                        if (last_bit) begin
                            diff <= d_next;
                            borr <= cell_bout;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed self-checking bench for serial_sub_ctrl
module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borr;

    int errors = 0;
    int checks = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .borr  (borr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one operation from IDLE; caller sits 1 time unit after a rising edge
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic ab, input logic [7:0] exp_d, input logic exp_b);
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic [7:0] d_seen;
        logic       b_seen;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        d_seen   = 8'h00;
        b_seen   = 1'b0;
        a = av;
        b = bv;
        start = 1'b1;
        abort = ab;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                start = 1'b0;
                abort = 1'b0;
                a = ~av;
                b = ~bv;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
                d_seen  = diff;
                b_seen  = borr;
            end
        end
        chk({tag, "_diff"},     32'(d_seen),   32'(exp_d));
        chk({tag, "_borr"},     32'(b_seen),   32'(exp_b));
        chk({tag, "_done_at"},  32'(done_at),  32'd8);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_cyc"}, 32'(busy_cnt), 32'd9);
    endtask

    logic [7:0] cont_d [3] = '{8'hFE, 8'hC2, 8'h86};
    logic       cont_b [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        int dcnt;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a = 8'h00;
        b = 8'h00;

        // reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borr", 32'(borr), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic results
        run_op("op5a3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        run_op("op0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run_op("op8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b0);

        // start held high: accepts at k=0,10,20, done at k=8,18,28
        for (int k = 0; k < 30; k++) begin
            a = 8'(k * 7 + 3);
            b = 8'(k * 13 + 5);
            start = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("cont_done_%0d", k), 32'(done), 32'((k % 10) == 8));
            if ((k % 10) == 8) begin
                chk($sformatf("cont_diff_%0d", k), 32'(diff), 32'(cont_d[(k - 8) / 10]));
                chk($sformatf("cont_borr_%0d", k), 32'(borr), 32'(cont_b[(k - 8) / 10]));
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;

        // abort mid-run keeps previous result
        run_op("pre_abort", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'h1E);
        chk("abort_borr", 32'(borr), 32'd0);
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);

        // asynchronous reset mid-run
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_borr", 32'(borr), 32'd0);
        #10;
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        chk("arst_no_done", 32'(dcnt), 32'd0);
        run_op("post_rst", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0);

        // start and abort together in IDLE: start wins
        run_op("start_abort", 8'hC4, 8'h4D, 1'b1, 8'h77, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single system clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on rising edge of clk.
REQ-005 Port: abort  input  1  synchronous cancel of an operation in progress.
REQ-006 Port: a  input  WIDTH  minuend; captured on the accepting edge only.
REQ-007 Port: b  input  WIDTH  subtrahend; captured on the accepting edge only.
REQ-008 Port: busy  output  1  high while state is not IDLE.
REQ-009 Port: done  output  1  one-cycle pulse marking valid result.
REQ-010 Port: diff  output  WIDTH  registered result a - b, modulo 2^WIDTH.
REQ-011 Port: borr  output  1  registered final borrow; high when a < b unsigned.

Function
REQ-012 The block SHALL compute a - b bit-serially, LSB first, one bit per clock, through one subtractor cell plus a borrow register.
REQ-013 The FSM SHALL have states IDLE, RUN, DONE.
REQ-014 IDLE SHALL go to RUN on an edge with start=1; on that edge it captures a and b into shift registers, clears the bit counter to 0 and the borrow register to 0.
REQ-015 start SHALL be ignored in RUN and DONE; no re-capture, no restart.
REQ-016 Each RUN edge SHALL produce bit[cnt] = a[cnt]^b[cnt]^bin, bout = (~a[cnt]&b[cnt]) | (~(a[cnt]^b[cnt])&bin), store bout as the next bin, and increment cnt.
REQ-017 RUN SHALL go to DONE on the edge that processes bit WIDTH-1; diff and borr update on that same edge.
REQ-018 Latency: with start accepted at edge E0, done SHALL be high during the cycle after edge E(WIDTH) and low again after edge E(WIDTH+1).
REQ-019 DONE SHALL go to IDLE unconditionally after one cycle; done = (state == DONE).
REQ-020 diff and borr SHALL hold their last completed values until the next completed operation, and are not updated bit-by-bit while in RUN.
REQ-021 abort=1 in RUN SHALL force IDLE on that edge, with no done pulse and diff/borr unchanged; in IDLE or DONE, abort has no effect.
REQ-022 If start=1 and abort=1 arrive together in IDLE, start SHALL win.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap inside one operation.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, diff=0, borr=0, counter=0 and borrow register=0, independent of clk.
REQ-025 Reset asserted mid-RUN SHALL discard the operation; after release, no done pulse is produced until a new start.
REQ-026 The first edge after rst_n deasserts SHALL be treated as a normal IDLE edge, so start can be accepted on it.

Structure
REQ-027 The shared package serial_sub_pkg SHALL hold the FSM state enumeration (2-bit encoding) and the WIDTH default constant.
REQ-028 The block SHALL contain exactly one sub-module, fs_cell: a combinational full subtractor (a, b, bin -> d, bout) built from two half subtractors and an OR.
REQ-029 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification (WIDTH=8)
REQ-030 a=0x5A, b=0x3C, start pulse -> done at E8+, diff=0x1E, borr=0, busy high for 9 cycles.
REQ-031 a=0x00, b=0x01 -> diff=0xFF, borr=1; then a=0x80, b=0x80 -> diff=0x00, borr=0.
REQ-032 start held high continuously for 30 cycles with changing a/b -> each operation uses the operands captured at its own accept edge, and done pulses every 10 cycles.
REQ-033 abort at E4 of a run with previous result 0x1E -> IDLE next cycle, no done, diff remains 0x1E.
REQ-034 rst_n low at E5 of a run -> outputs 0 asynchronously, no done after release; a new start yields the correct result.
REQ-035 start and abort high together in IDLE -> operation runs to completion with the correct result.
